// File: rtl/ex_mem_stage_pkg.sv
// Shared types and defaults for the EX/MEM pipeline stage.
package ex_mem_stage_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 5;
   localparam int CNT_W_DEF  = 32;

   // MEM/WB control bits carried by the stage
   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
   } mem_ctrl_t;

   localparam mem_ctrl_t CTRL_BUBBLE = '0;

   // What the pipeline register does on the next edge
   typedef enum logic [1:0] {
      LOAD_CAPTURE = 2'd0,
      LOAD_HOLD    = 2'd1,
      LOAD_BUBBLE  = 2'd2
   } load_sel_e;

   // Branch pulse flag: fires for one cycle after a captured taken beq
   typedef enum logic {
      PULSE_IDLE  = 1'b0,
      PULSE_FIRED = 1'b1
   } pulse_state_e;

   // flush beats stall, stall beats capture; an invalid EX slot becomes a bubble
   function automatic load_sel_e load_select(input logic flush, input logic stall,
                                             input logic ex_valid);
      if (flush)     return LOAD_BUBBLE;
      if (stall)     return LOAD_HOLD;
      if (!ex_valid) return LOAD_BUBBLE;
      return LOAD_CAPTURE;
   endfunction

   // Word accesses must have the two address LSBs clear
   function automatic logic is_misaligned(input logic [1:0] addr_lsb);
      return addr_lsb != 2'b00;
   endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Bus between the EX stage / hazard unit and the EX/MEM register.
// Optional MEM_ALIGN_CHECK_EN adds the mem_misaligned signal.
interface ex_mem_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic              stall;
   logic              flush;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_alu_result;
   logic              ex_zero;
   logic [DATA_W-1:0] ex_write_data;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic              ex_mem_to_reg;
   logic              ex_branch;
   logic [DATA_W-1:0] ex_branch_target;

   logic              mem_valid;
   logic              mem_reg_write;
   logic              mem_mem_read;
   logic              mem_mem_write;
   logic              mem_mem_to_reg;
   logic [DATA_W-1:0] mem_alu_result;
   logic [DATA_W-1:0] mem_write_data;
   logic [REG_AW-1:0] mem_rd;
   logic              branch_taken;
   logic [DATA_W-1:0] branch_target;
   logic              flush_req;
   logic              fwd_valid;
   logic [REG_AW-1:0] fwd_rd;
   logic [DATA_W-1:0] fwd_data;
   logic [CNT_W-1:0]  stall_cycles;
`ifdef MEM_ALIGN_CHECK_EN
   logic              mem_misaligned;
`endif

   // Upstream side: EX stage and hazard unit drive, MEM consumers read
   modport master (
`ifdef MEM_ALIGN_CHECK_EN
      input  mem_misaligned,
`endif
      output stall, flush, ex_valid, ex_alu_result, ex_zero, ex_write_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch,
             ex_branch_target,
      input  mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
             mem_alu_result, mem_write_data, mem_rd, branch_taken, branch_target,
             flush_req, fwd_valid, fwd_rd, fwd_data, stall_cycles
   );

   // The EX/MEM register itself
   modport slave (
`ifdef MEM_ALIGN_CHECK_EN
      output mem_misaligned,
`endif
      input  stall, flush, ex_valid, ex_alu_result, ex_zero, ex_write_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch,
             ex_branch_target,
      output mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
             mem_alu_result, mem_write_data, mem_rd, branch_taken, branch_target,
             flush_req, fwd_valid, fwd_rd, fwd_data, stall_cycles
   );
endinterface

// File: rtl/ex_mem_stage_branch_resolve.sv
// beq resolution: taken decision from the zero flag, a one-shot pulse flag
// and the registered branch target.
module ex_mem_stage_branch_resolve
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              capture,
   input  logic              ex_valid,
   input  logic              ex_branch,
   input  logic              ex_zero,
   input  logic [DATA_W-1:0] ex_branch_target,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_target
);

   pulse_state_e      state_q, state_d;
   logic [DATA_W-1:0] target_q, target_d;
   logic              taken_d;

   assign taken_d = ex_valid & ex_branch & ex_zero;

   // Arm the pulse only on a captured taken branch; every other cycle disarms it
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d  = PULSE_IDLE;
      target_d = target_q;
      if (capture) begin
         target_d = ex_branch_target;
         if (taken_d) state_d = PULSE_FIRED;
      end
   end

   // Pulse flag and target registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state is updated with non-blocking assignments so all flops sample the same edge.
      if (reset) begin
         state_q  <= PULSE_IDLE;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
      end
   end

   assign branch_taken  = (state_q == PULSE_FIRED);
   assign branch_target = target_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register of the five-stage MIPS core: registers the ALU
// result, store data, destination and MEM/WB controls, resolves beq, drives
// MEM->EX forwarding and counts stall cycles.
// Optional MEM_ALIGN_CHECK_EN: flags misaligned lw/sw and suppresses the access.
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic          clk,
   input  logic          reset,
   ex_mem_stage_if.slave bus
);

   load_sel_e         load_sel;
   logic              capture;
   logic              access_bad;
   logic              branch_taken;

   logic              valid_q, valid_d;
   mem_ctrl_t         ctrl_q, ctrl_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   assign load_sel = load_select(bus.flush, bus.stall, bus.ex_valid);
   assign capture  = (load_sel == LOAD_CAPTURE);

`ifdef MEM_ALIGN_CHECK_EN
   logic misaligned_q, misaligned_d;

   assign access_bad = bus.ex_valid & (bus.ex_mem_read | bus.ex_mem_write)
                     & is_misaligned(bus.ex_alu_result[1:0]);

   // Misalignment flag follows the same load/hold/bubble rule as the other fields
   always_comb begin
      misaligned_d = misaligned_q;
      unique case (load_sel)
         LOAD_CAPTURE: misaligned_d = access_bad;
         LOAD_BUBBLE:  misaligned_d = 1'b0;
         default:      misaligned_d = misaligned_q;
      endcase
   end

   // Misalignment flag register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) misaligned_q <= 1'b0;
      else       misaligned_q <= misaligned_d;
   end

   assign bus.mem_misaligned = misaligned_q;
`else
   assign access_bad = 1'b0;
`endif

   // Pipeline register next state: capture EX, hold on stall, or load a bubble
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      alu_d   = alu_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      unique case (load_sel)
         LOAD_CAPTURE: begin
            valid_d            = 1'b1;
            ctrl_d.reg_write   = bus.ex_reg_write;
            ctrl_d.mem_read    = bus.ex_mem_read  & ~access_bad;
            ctrl_d.mem_write   = bus.ex_mem_write & ~access_bad;
            ctrl_d.mem_to_reg  = bus.ex_mem_to_reg;
            alu_d              = bus.ex_alu_result;
            wdata_d            = bus.ex_write_data;
            rd_d               = bus.ex_rd;
         end
         LOAD_BUBBLE: begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
            alu_d   = '0;
            wdata_d = '0;
            rd_d    = '0;
         end
         default: ;
      endcase
   end

   // Stall counter: counts every stall cycle, flush or not, and sticks at all-ones
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (bus.stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // Pipeline and counter registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q     <= 1'b0;
         ctrl_q      <= CTRL_BUBBLE;
         alu_q       <= '0;
         wdata_q     <= '0;
         rd_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         ctrl_q      <= ctrl_d;
         alu_q       <= alu_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   ex_mem_stage_branch_resolve #(
      .DATA_W (DATA_W)
   ) u_branch_resolve (
      .clk              (clk),
      .reset            (reset),
      .capture          (capture),
      .ex_valid         (bus.ex_valid),
      .ex_branch        (bus.ex_branch),
      .ex_zero          (bus.ex_zero),
      .ex_branch_target (bus.ex_branch_target),
      .branch_taken     (branch_taken),
      .branch_target    (bus.branch_target)
   );

   assign bus.mem_valid      = valid_q;
   assign bus.mem_reg_write  = ctrl_q.reg_write;
   assign bus.mem_mem_read   = ctrl_q.mem_read;
   assign bus.mem_mem_write  = ctrl_q.mem_write;
   assign bus.mem_mem_to_reg = ctrl_q.mem_to_reg;
   assign bus.mem_alu_result = alu_q;
   assign bus.mem_write_data = wdata_q;
   assign bus.mem_rd         = rd_q;
   assign bus.branch_taken   = branch_taken;
   assign bus.flush_req      = branch_taken;
   assign bus.stall_cycles   = stall_cnt_q;

   // A load's value is not known until MEM completes, and r0 is never forwarded
   assign bus.fwd_valid = valid_q & ctrl_q.reg_write & ~ctrl_q.mem_read & (rd_q != '0);
   assign bus.fwd_rd    = rd_q;
   assign bus.fwd_data  = alu_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_ex_mem_stage;

   localparam int DATA_W  = 32;
   localparam int REG_AW  = 5;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ex_mem_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

   ex_mem_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      bit              valid, rw, mr, mw, m2r, bt, mis;
      bit [DATA_W-1:0] alu, wd, tgt;
      bit [REG_AW-1:0] rd;
      int              cnt;
   } model_t;

   model_t m;
   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m = '{default: 0};
   endtask

   // One rising edge of the stage, stated directly from the pipeline rules
   task automatic model_step();
      bit bad;
      if (reset) begin
         model_clear();
         return;
      end
      if (bus.stall) m.cnt = (m.cnt == CNT_MAX) ? CNT_MAX : m.cnt + 1;
      if (bus.flush || (!bus.stall && !bus.ex_valid)) begin
         m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0;
         m.alu = 0; m.wd = 0; m.rd = 0; m.bt = 0; m.mis = 0;
      end else if (bus.stall) begin
         m.bt = 0;
      end else begin
         bad     = ALIGN_CHECK && (bus.ex_mem_read || bus.ex_mem_write)
                   && (bus.ex_alu_result % 4 != 0);
         m.valid = 1;
         m.rw    = bus.ex_reg_write;
         m.mr    = bus.ex_mem_read && !bad;
         m.mw    = bus.ex_mem_write && !bad;
         m.m2r   = bus.ex_mem_to_reg;
         m.alu   = bus.ex_alu_result;
         m.wd    = bus.ex_write_data;
         m.rd    = bus.ex_rd;
         m.mis   = bad;
         m.bt    = bus.ex_branch && bus.ex_zero;
         m.tgt   = bus.ex_branch_target;
      end
   endtask

   task automatic check_outputs(input string tag);
      bit fwd;
      fwd = m.valid && m.rw && !m.mr && (m.rd != 0);
      check({tag, ".mem_valid"},      bus.mem_valid,      m.valid);
      check({tag, ".mem_reg_write"},  bus.mem_reg_write,  m.rw);
      check({tag, ".mem_mem_read"},   bus.mem_mem_read,   m.mr);
      check({tag, ".mem_mem_write"},  bus.mem_mem_write,  m.mw);
      check({tag, ".mem_mem_to_reg"}, bus.mem_mem_to_reg, m.m2r);
      check({tag, ".mem_alu_result"}, bus.mem_alu_result, m.alu);
      check({tag, ".mem_write_data"}, bus.mem_write_data, m.wd);
      check({tag, ".mem_rd"},         bus.mem_rd,         m.rd);
      check({tag, ".branch_taken"},   bus.branch_taken,   m.bt);
      check({tag, ".flush_req"},      bus.flush_req,      m.bt);
      check({tag, ".branch_target"},  bus.branch_target,  m.tgt);
      check({tag, ".fwd_valid"},      bus.fwd_valid,      fwd);
      check({tag, ".fwd_rd"},         bus.fwd_rd,         m.rd);
      check({tag, ".fwd_data"},       bus.fwd_data,       m.alu);
      check({tag, ".stall_cycles"},   bus.stall_cycles,   m.cnt);
`ifdef MEM_ALIGN_CHECK_EN
      check({tag, ".mem_misaligned"}, bus.mem_misaligned, m.mis);
`endif
   endtask

   task automatic set_ex(input bit valid, input logic [DATA_W-1:0] alu,
                         input logic [DATA_W-1:0] wd, input logic [REG_AW-1:0] rd,
                         input bit rw, input bit mr, input bit mw, input bit m2r,
                         input bit br, input logic [DATA_W-1:0] tgt);
      bus.ex_valid         = valid;
      bus.ex_alu_result    = alu;
      bus.ex_zero          = (alu == '0);
      bus.ex_write_data    = wd;
      bus.ex_rd            = rd;
      bus.ex_reg_write     = rw;
      bus.ex_mem_read      = mr;
      bus.ex_mem_write     = mw;
      bus.ex_mem_to_reg    = m2r;
      bus.ex_branch        = br;
      bus.ex_branch_target = tgt;
   endtask

   task automatic set_idle();
      set_ex(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
   endtask

   // Advance one edge, update the model, then sample 1 time unit later
   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_outputs(tag);
   endtask

   initial begin
      model_clear();
      reset     = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      set_idle();
      #1;
      check_outputs("reset_async");
      cycle("reset_edge");
      reset = 1'b0;

      // add r3 = 0x10
      set_ex(1, 32'h10, 32'h0, 5'd3, 1, 0, 0, 0, 0, 32'h0);
      cycle("add");
      check("add.alu_result", bus.mem_alu_result, 32'h10);
      check("add.fwd_valid", bus.fwd_valid, 1'b1);
      check("add.fwd_rd", bus.fwd_rd, 5'd3);

      // taken beq, then three stall cycles
      set_ex(1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 32'h40);
      cycle("beq");
      check("beq.taken", bus.branch_taken, 1'b1);
      check("beq.flush_req", bus.flush_req, 1'b1);
      set_ex(1, 32'h4, 32'h0, 5'd7, 1, 0, 0, 0, 0, 32'h80);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle("beq_stall");
         check("beq_stall.taken", bus.branch_taken, 1'b0);
         check("beq_stall.target", bus.branch_target, 32'h40);
      end
      check("beq_stall.count", bus.stall_cycles, 4'd3);

      // flush wins over stall for a valid lw
      set_ex(1, 32'h100, 32'h0, 5'd5, 1, 1, 0, 1, 0, 32'h0);
      bus.flush = 1'b1;
      cycle("flush_stall");
      check("flush_stall.valid", bus.mem_valid, 1'b0);
      check("flush_stall.mem_read", bus.mem_mem_read, 1'b0);
      bus.flush = 1'b0;
      bus.stall = 1'b0;

      // lw never forwards; neither does a write to r0
      cycle("lw");
      check("lw.fwd_valid", bus.fwd_valid, 1'b0);
      check("lw.mem_read", bus.mem_mem_read, 1'b1);
      set_ex(1, 32'h1234, 32'h0, 5'd0, 1, 0, 0, 0, 0, 32'h0);
      cycle("r0");
      check("r0.fwd_valid", bus.fwd_valid, 1'b0);
      set_idle();
      cycle("bubble");
      check("bubble.valid", bus.mem_valid, 1'b0);

      // reset between edges while the branch pulse is high
      set_ex(1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 32'h44);
      cycle("beq2");
      check("beq2.taken", bus.branch_taken, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      model_clear();
      check_outputs("reset_mid_pulse");
      check("reset_mid_pulse.taken", bus.branch_taken, 1'b0);
      set_idle();
      cycle("reset_hold");
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cycle("after_reset");
         check("after_reset.taken", bus.branch_taken, 1'b0);
      end

`ifdef MEM_ALIGN_CHECK_EN
      set_ex(1, 32'h6, 32'hDEAD, 5'd0, 0, 0, 1, 0, 0, 32'h0);
      cycle("sw_mis");
      check("sw_mis.flag", bus.mem_misaligned, 1'b1);
      check("sw_mis.write", bus.mem_mem_write, 1'b0);
      set_ex(1, 32'h8, 32'hBEEF, 5'd0, 0, 0, 1, 0, 0, 32'h0);
      cycle("sw_ok");
      check("sw_ok.flag", bus.mem_misaligned, 1'b0);
      check("sw_ok.write", bus.mem_mem_write, 1'b1);
`endif

      // counter saturation
      bus.stall = 1'b1;
      for (int i = 0; i < CNT_MAX + 5; i++) begin
         set_ex(1, $urandom, $urandom, 5'($urandom_range(0, 31)), 1, 0, 0, 0, 1, $urandom);
         cycle("sat");
      end
      check("sat.count", bus.stall_cycles, 4'hF);

      // reset in the middle of a stall
      #2;
      reset = 1'b1;
      #1;
      model_clear();
      check_outputs("reset_mid_stall");
      check("reset_mid_stall.count", bus.stall_cycles, 4'h0);
      cycle("reset_mid_stall_edge");
      reset = 1'b0;

      // random traffic
      for (int i = 0; i < 400; i++) begin
         bus.stall = ($urandom_range(0, 3) == 0);
         bus.flush = ($urandom_range(0, 9) == 0);
         set_ex(($urandom_range(0, 4) != 0),
                ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom,
                $urandom, 5'($urandom_range(0, 7)),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom);
         cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
